vx_fpu_share_arb: RTL and testbench

//  Shares one non-pipelined FPU unit (e.g. iterative div/sqrt) between NUM_REQS requesters.
//  - Round-robin grant; one operation outstanding at a time.
//  - Result is routed back to the owning requester.
//  - Keeps a per-requester sticky fflags accumulator (NV,DZ,OF,UF,NX at [4:0]) for CSR readout.

---
 rtl/vx_fpu_share_arb.sv | 184 ++++++++++++++++++
 tb/tb_vx_fpu_share_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_fpu_share_arb.sv
// Round-robin arbiter in front of one shared, non-pipelined FPU unit.
// One operation is in flight at a time. The result goes back to the requester
// that issued it, and each requester keeps a sticky copy of its exception flags
// so the CSR block can read them out.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no operation in flight; grant offered to the unit
// WAIT  | operation accepted by the unit, waiting for its response
// RESP  | result registered, presented to the owning requester
module vx_fpu_share_arb #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 96,
    parameter int RESW     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       in_valid,
    input  logic [NUM_REQS*DATAW-1:0] in_data,
    output logic [NUM_REQS-1:0]       in_ready,
    output logic                      unit_req_valid,
    output logic [DATAW-1:0]          unit_req_data,
    input  logic                      unit_req_ready,
    input  logic                      unit_rsp_valid,
    input  logic [RESW-1:0]           unit_rsp_data,
    input  logic [4:0]                unit_rsp_fflags,
    output logic [NUM_REQS-1:0]       out_valid,
    output logic [RESW-1:0]           out_data,
    output logic [4:0]                out_fflags,
    input  logic [NUM_REQS-1:0]       out_ready,
    input  logic [NUM_REQS-1:0]       flags_clear,
    output logic [NUM_REQS*5-1:0]     flags_sticky,
    output logic                      busy
);

    localparam int IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IDXW-1:0] last_grant;
    logic [IDXW-1:0] owner;
    logic [IDXW-1:0] grant;
    logic [IDXW-1:0] cand;
    logic            grant_found;
    logic            req_fire;
    logic            rsp_take;
    logic            out_fire;
    logic            rsp_orphan;
    logic [4:0]      sticky [NUM_REQS];
    logic [DATAW-1:0] in_data_a [NUM_REQS];

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_lanes
        assign in_data_a[gi]             = in_data[gi*DATAW +: DATAW];
        assign flags_sticky[gi*5 +: 5]   = sticky[gi];
    end

    function automatic logic [IDXW-1:0] rr_idx(input logic [IDXW-1:0] base, input int k);
        int sum;
        sum = (int'(base) + k) % NUM_REQS;
        return IDXW'(sum);
    endfunction

    // Round-robin pick: first valid requester after the last one served.
    always_comb begin
        grant       = last_grant;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            cand = rr_idx(last_grant, k);
            if (!grant_found && in_valid[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    // Next state, handshake qualifiers and per-state outputs.
    always_comb begin
        state_n        = state;
        in_ready       = '0;
        unit_req_valid = 1'b0;
        unit_req_data  = in_data_a[grant];
        out_valid      = '0;
        req_fire       = 1'b0;
        rsp_take       = 1'b0;
        out_fire       = 1'b0;
        case (state)
            ST_IDLE: begin
                unit_req_valid = grant_found;
                if (grant_found) begin
                    in_ready[grant] = unit_req_ready;
                end
                req_fire = grant_found && unit_req_ready;
                if (req_fire) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rsp_take = unit_rsp_valid;
                if (rsp_take) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                out_valid[owner] = 1'b1;
                out_fire         = out_ready[owner];
                if (out_fire) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    // State register, owner capture, result register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= IDXW'(NUM_REQS - 1);
            owner      <= '0;
            out_data   <= '0;
            out_fflags <= '0;
        end else begin
            state <= state_n;
            if (req_fire) begin
                owner <= grant;
            end
            if (rsp_take) begin
                out_data   <= unit_rsp_data;
                out_fflags <= unit_rsp_fflags;
            end
            if (out_fire) begin
                last_grant <= owner;
            end
        end
    end

    // Sticky flag accumulators; a same-cycle clear keeps only the newly retired flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                sticky[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (flags_clear[i]) begin
                    sticky[i] <= (out_fire && owner == IDXW'(i)) ? out_fflags : 5'b0;
                end else if (out_fire && owner == IDXW'(i)) begin
                    sticky[i] <= sticky[i] | out_fflags;
                end
            end
        end
    end

    // Remembers that a reset dropped an op in WAIT, so its late response is tolerated.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_orphan <= rsp_orphan || (state == ST_WAIT);
        end else if (req_fire) begin
            rsp_orphan <= 1'b0;
        end else if (unit_rsp_valid && state != ST_WAIT) begin
            rsp_orphan <= 1'b0;
        end
    end

    // A response outside WAIT is a unit protocol violation unless it belongs to a dropped op.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(unit_rsp_valid && state != ST_WAIT && !rsp_orphan))
                else $error("vx_fpu_share_arb: unit response with no operation outstanding");
        end
    end

endmodule

// File: tb/tb_vx_fpu_share_arb.sv
// Bench for vx_fpu_share_arb: directed scenarios plus a random soak, all checked
// against a transaction-level model of the arbiter and a scripted shared unit.
module tb_vx_fpu_share_arb;

    localparam int NR = 4;
    localparam int DW = 96;
    localparam int RW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   in_valid;
    logic [NR*DW-1:0] in_data;
    logic [NR-1:0]   in_ready;
    logic            unit_req_valid;
    logic [DW-1:0]   unit_req_data;
    logic            unit_req_ready;
    logic            unit_rsp_valid;
    logic [RW-1:0]   unit_rsp_data;
    logic [4:0]      unit_rsp_fflags;
    logic [NR-1:0]   out_valid;
    logic [RW-1:0]   out_data;
    logic [4:0]      out_fflags;
    logic [NR-1:0]   out_ready;
    logic [NR-1:0]   flags_clear;
    logic [NR*5-1:0] flags_sticky;
    logic            busy;

    always #5 clk = ~clk;

    vx_fpu_share_arb #(.NUM_REQS(NR), .DATAW(DW), .RESW(RW)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .unit_req_valid  (unit_req_valid),
        .unit_req_data   (unit_req_data),
        .unit_req_ready  (unit_req_ready),
        .unit_rsp_valid  (unit_rsp_valid),
        .unit_rsp_data   (unit_rsp_data),
        .unit_rsp_fflags (unit_rsp_fflags),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_fflags      (out_fflags),
        .out_ready       (out_ready),
        .flags_clear     (flags_clear),
        .flags_sticky    (flags_sticky),
        .busy            (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: m_phase 0 = nothing outstanding, 1 = op inside unit, 2 = result awaiting owner.
    int          m_phase;
    int          m_last;
    int          m_owner;
    logic [31:0] m_res;
    logic [4:0]  m_flg;
    logic [4:0]  m_sticky [NR];
    int          rsp_cnt;
    logic [31:0] pend_dat;
    logic [4:0]  pend_flg;
    logic [DW-1:0] pay [NR];
    int          grant_log [$];

    task automatic run_cycle(input logic [3:0] v, input logic [3:0] ordy, input logic urdy,
                             input logic [3:0] clr, input int lat, input logic [31:0] rdat,
                             input logic [4:0] rflg, input logic stray);
        int          ph;
        int          g;
        int          idx;
        int          dg;
        logic        fire_rsp;
        logic        upd;
        logic        exp_req;
        logic [3:0]  exp_rdy;
        logic [3:0]  exp_ov;
        logic [19:0] exp_st;
        ph = m_phase;
        in_valid       = v;
        out_ready      = ordy;
        unit_req_ready = urdy;
        flags_clear    = clr;
        for (int i = 0; i < NR; i++) begin
            pay[i] = {$urandom, $urandom, $urandom};
            in_data[i*DW +: DW] = pay[i];
        end
        fire_rsp = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            fire_rsp = (rsp_cnt == 0);
        end
        unit_rsp_valid  = fire_rsp | stray;
        unit_rsp_data   = fire_rsp ? pend_dat : $urandom;
        unit_rsp_fflags = fire_rsp ? pend_flg : 5'($urandom);
        #1;
        g = -1;
        if (ph == 0) begin
            for (int k = 1; k <= NR; k++) begin
                idx = (m_last + k) % NR;
                if (g < 0 && ((v >> idx) & 4'b0001) != 0) g = idx;
            end
        end
        exp_req = (g >= 0);
        exp_rdy = (g >= 0 && urdy) ? (4'b0001 << g) : 4'b0000;
        exp_ov  = (ph == 2) ? (4'b0001 << m_owner) : 4'b0000;
        for (int i = 0; i < NR; i++) exp_st[i*5 +: 5] = m_sticky[i];
        chk_eq("unit_req_valid", unit_req_valid, exp_req);
        if (g >= 0) chk_eq("unit_req_data", unit_req_data, pay[g]);
        chk_eq("in_ready", in_ready, exp_rdy);
        chk_eq("busy", busy, ph != 0);
        chk_eq("out_valid", out_valid, exp_ov);
        chk_eq("out_data", out_data, m_res);
        chk_eq("out_fflags", out_fflags, m_flg);
        chk_eq("flags_sticky", flags_sticky, exp_st);
        upd = (ph == 2) && (((ordy >> m_owner) & 4'b0001) != 0);
        if (ph == 0 && g >= 0 && urdy) begin
            dg = -1;
            for (int i = 0; i < NR; i++) if (((in_ready >> i) & 4'b0001) != 0) dg = i;
            grant_log.push_back(dg);
            m_owner  = g;
            m_phase  = 1;
            rsp_cnt  = lat;
            pend_dat = rdat;
            pend_flg = rflg;
        end else if (ph == 1 && fire_rsp) begin
            m_res   = pend_dat;
            m_flg   = pend_flg;
            m_phase = 2;
        end
        for (int i = 0; i < NR; i++) begin
            if (((clr >> i) & 4'b0001) != 0) m_sticky[i] = 5'b0;
            if (upd && i == m_owner) m_sticky[i] = m_sticky[i] | m_flg;
        end
        if (upd) begin
            m_last  = m_owner;
            m_phase = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        in_valid       = '0;
        out_ready      = '0;
        unit_req_ready = 1'b0;
        unit_rsp_valid = 1'b0;
        flags_clear    = '0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_phase = 0;
        m_last  = NR - 1;
        m_owner = 0;
        m_res   = '0;
        m_flg   = '0;
        rsp_cnt = 0;
        for (int i = 0; i < NR; i++) m_sticky[i] = '0;
    endtask

    task automatic idle_cyc();
        run_cycle(4'b0000, 4'b0000, 1'b1, 4'b0000, 1, 32'h0, 5'h0, 1'b0);
    endtask

    task automatic do_op(input int req, input int lat, input logic [31:0] dat,
                         input logic [4:0] flg, input logic [3:0] clr_at_done);
        int n;
        logic [3:0] rv;
        rv = 4'b0001 << req;
        n = 0;
        while (m_phase == 0 && n < 20) begin
            run_cycle(rv, 4'b0000, 1'b1, 4'b0000, lat, dat, flg, 1'b0);
            n++;
        end
        n = 0;
        while (m_phase == 1 && n < 30) begin
            idle_cyc();
            n++;
        end
        chk_eq("op_reached_resp", m_phase == 2, 1'b1);
        run_cycle(4'b0000, rv, 1'b1, clr_at_done, 1, 32'h0, 5'h0, 1'b0);
    endtask

    initial begin
        int n;
        logic [31:0] held;
        reset = 1'b1;
        in_data = '0;
        unit_rsp_data = '0;
        unit_rsp_fflags = '0;
        do_reset();

        // single request, latency 5
        run_cycle(4'b0001, 4'b0000, 1'b1, 4'b0000, 5, 32'h3F800000, 5'h0, 1'b0);
        n = 1;
        while (out_valid == 4'b0000 && n < 20) begin
            idle_cyc();
            n++;
        end
        chk_eq("t1_latency", n, 6);
        chk_eq("t1_out_valid", out_valid, 4'b0001);
        chk_eq("t1_out_data", out_data, 32'h3F800000);
        run_cycle(4'b0000, 4'b0001, 1'b1, 4'b0000, 1, 32'h0, 5'h0, 1'b0);

        // fairness with everyone requesting
        do_reset();
        grant_log.delete();
        n = 0;
        while (grant_log.size() < 5 && n < 200) begin
            run_cycle(4'b1111, 4'b1111, 1'b1, 4'b0000, $urandom_range(1, 3), $urandom, 5'h0, 1'b0);
            n++;
        end
        chk_eq("t2_ops", grant_log.size(), 5);
        for (int j = 0; j < grant_log.size() && j < 5; j++) chk_eq("t2_grant_order", grant_log[j], j % 4);
        n = 0;
        while (m_phase != 0 && n < 20) begin
            run_cycle(4'b0000, 4'b1111, 1'b1, 4'b0000, 1, 32'h0, 5'h0, 1'b0);
            n++;
        end

        // backpressure from owner 3 for 10 cycles
        n = 0;
        while (m_phase == 0 && n < 20) begin
            run_cycle(4'b1000, 4'b0000, 1'b1, 4'b0000, 2, 32'hCAFEF00D, 5'b00100, 1'b0);
            n++;
        end
        n = 0;
        while (m_phase == 1 && n < 20) begin
            idle_cyc();
            n++;
        end
        held = out_data;
        for (int c = 0; c < 10; c++) begin
            run_cycle(4'b1111, 4'b0111, 1'b1, 4'b0000, 1, 32'h0, 5'h0, 1'b0);
            chk_eq("t3_hold_data", out_data, 32'hCAFEF00D);
            chk_eq("t3_hold_valid", out_valid, 4'b1000);
        end
        chk_eq("t3_held_value", held, 32'hCAFEF00D);
        run_cycle(4'b0000, 4'b1000, 1'b1, 4'b0000, 1, 32'h0, 5'h0, 1'b0);

        // sticky accumulation and clear for requester 2
        do_reset();
        do_op(2, 3, $urandom, 5'b00001, 4'b0000);
        do_op(2, 2, $urandom, 5'b01000, 4'b0000);
        chk_eq("t4_sticky_acc", flags_sticky[14:10], 5'b01001);
        run_cycle(4'b0000, 4'b0000, 1'b1, 4'b0100, 1, 32'h0, 5'h0, 1'b0);
        chk_eq("t4_sticky_clr", flags_sticky[14:10], 5'b00000);

        // clear colliding with update for requester 1
        do_op(1, 2, $urandom, 5'b00001, 4'b0000);
        chk_eq("t5_sticky_pre", flags_sticky[9:5], 5'b00001);
        do_op(1, 2, $urandom, 5'b10000, 4'b0010);
        chk_eq("t5_sticky_collide", flags_sticky[9:5], 5'b10000);

        // reset in WAIT, then a stray late response
        do_op(2, 1, $urandom, 5'h0, 4'b0000);
        run_cycle(4'b0001, 4'b0000, 1'b1, 4'b0000, 6, 32'h12345678, 5'h3, 1'b0);
        idle_cyc();
        chk_eq("t6_busy_wait", busy, 1'b1);
        do_reset();
        run_cycle(4'b0000, 4'b0000, 1'b1, 4'b0000, 1, 32'h0, 5'h0, 1'b1);
        chk_eq("t6_out_valid", out_valid, 4'b0000);
        chk_eq("t6_busy", busy, 1'b0);
        chk_eq("t6_out_data", out_data, 32'h0);
        in_valid = 4'b1111;
        unit_req_ready = 1'b1;
        #1;
        chk_eq("t6_next_grant", in_ready, 4'b0001);
        run_cycle(4'b1111, 4'b0000, 1'b1, 4'b0000, 2, $urandom, 5'h0, 1'b0);
        n = 0;
        while (m_phase != 0 && n < 20) begin
            run_cycle(4'b0000, 4'b1111, 1'b1, 4'b0000, 1, 32'h0, 5'h0, 1'b0);
            n++;
        end

        // random soak
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            run_cycle(4'($urandom), 4'($urandom), 1'($urandom),
                      ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000,
                      $urandom_range(1, 6), $urandom, 5'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
